sig_monitor: RTL

- Synthesizable end-of-test monitor for the rv32i core.
- Snoops the data-memory write port (wr_en, wr_addr, mode, d_out) and keeps a byte-merged shadow copy of an N_SIG-word signature region.
- Detects the PASS-flag store or a cycle timeout, then compares the shadow words against expected values, one word per cycle.
- Lets regression benches and FPGA builds get PASS/FAIL from hardware rather than from hierarchical memory peeks.

---
 rtl/sig_monitor_pkg.sv | 49 ++++
 rtl/sig_monitor_shadow_ram.sv | 37 +++
 rtl/sig_monitor.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sig_monitor_pkg.sv
// sig_monitor_pkg: shared types and store-decode helpers for the
// end-of-test signature monitor.
//   state_e      - monitor FSM states
//   MODE_*       - data-memory store size encodings
//   be_from_mode - {legal, byte-enable[3:0]} for a store size and address
//   lane_align   - places right-aligned store data onto its byte lanes
package sig_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] MODE_B = 2'd0;
   localparam logic [1:0] MODE_H = 2'd1;
   localparam logic [1:0] MODE_W = 2'd2;

   // Bit 4 is the legality flag; a reserved mode or a misaligned store
   // returns all zeros so nothing is captured.
   function automatic logic [4:0] be_from_mode(input logic [1:0] mode,
                                               input logic [1:0] addr);
      logic [4:0] r;
      r = 5'b0;
      case (mode)
         MODE_B:  r = {1'b1, 4'(4'b0001 << addr)};
         MODE_H:  if (!addr[0]) r = {1'b1, (addr[1] ? 4'b1100 : 4'b0011)};
         MODE_W:  if (addr == 2'b00) r = 5'b11111;
         default: r = 5'b0;
      endcase
      return r;
   endfunction

   // Same lane placement as the data memory: byte to lane addr[1:0],
   // half to lanes addr[1]*2 and addr[1]*2+1, word unchanged.
   function automatic logic [31:0] lane_align(input logic [1:0]  mode,
                                              input logic [1:0]  addr,
                                              input logic [31:0] data);
      logic [31:0] r;
      case (mode)
         MODE_B:  r = {24'b0, data[7:0]}  << {addr, 3'b000};
         MODE_H:  r = {16'b0, data[15:0]} << {addr[1], 4'b0000};
         default: r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sig_monitor_shadow_ram.sv
// sig_shadow_ram: N_SIG x 32 shadow register file.
//   clk, rst  - clock, synchronous active-high reset (clears all words)
//   clr       - synchronous clear of all words
//   we, widx  - write strobe and word index
//   be, wdata - byte enables and lane-placed write data
//   ridx      - combinational read index
//   rdata     - read data (0 for an out-of-range index)
module sig_shadow_ram #(
   parameter int N_SIG = 5,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [3:0]       be,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] ridx,
   output logic [31:0]      rdata
);

   logic [N_SIG-1:0][31:0] mem_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         mem_q <= '0;
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = (int'(ridx) < N_SIG) ? mem_q[ridx] : 32'h0;

endmodule

// File: rtl/sig_monitor.sv
// sig_monitor: end-of-test monitor for the rv32i core.
// Snoops data-memory stores, keeps a byte-merged shadow of the signature
// region, waits for the PASS flag (or a timeout), then compares one shadow
// word per cycle against exp_sig and holds a registered verdict.
//   clk, rst        - clock, synchronous active-high reset
//   start           - arms the monitor from IDLE or DONE
//   wr_en, wr_addr, mode, d_out - snooped store port
//   exp_sig         - expected words, word i at [32i+31:32i]
//   busy, done      - RUN/CHECK and DONE indicators
//   pass, fail      - verdict, valid while done
//   timed_out       - RUN ended by timeout
//   misaligned      - sticky illegal-store flag
//   fail_mask       - per-word mismatch bits
//   cycles          - RUN cycle count
module sig_monitor
   import sig_monitor_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_W     = 32,
   parameter int                    N_SIG      = 5,
   parameter logic [ADDR_WIDTH-1:0] SIG_BASE   = 'h80,
   parameter logic [ADDR_WIDTH-1:0] PASS_ADDR  = 'h08,
   parameter int                    TIMEOUT    = 2000,
   parameter int                    CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [1:0]            mode,
   input  logic [DATA_W-1:0]     d_out,
   input  logic [N_SIG*32-1:0]   exp_sig,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic                  timed_out,
   output logic                  misaligned,
   output logic [N_SIG-1:0]      fail_mask,
   output logic [CNT_W-1:0]      cycles
);

   localparam int IDX_W   = (N_SIG > 1) ? $clog2(N_SIG) : 1;
   localparam int SIG_END = int'(SIG_BASE) + 4 * N_SIG;

   state_e             state_q;
   logic               busy_q, done_q, pass_q, fail_q;
   logic               timed_out_q, misaligned_q, pass_seen_q;
   logic [N_SIG-1:0]   fail_mask_q, fail_mask_d;
   logic [CNT_W-1:0]   cycles_q;
   logic [IDX_W-1:0]   chk_idx_q;
   logic [31:0]        pflag_q, pflag_d;

   // ---- store decode ----
   logic [4:0]       be_info;
   logic             legal;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic             in_run, st_ok, st_bad, sig_hit, flag_word, flag_hit, tmo_hit;
   logic [IDX_W-1:0] sig_idx;

   assign be_info   = be_from_mode(mode, wr_addr[1:0]);
   assign legal     = be_info[4];
   assign be        = be_info[3:0];
   assign wdata     = lane_align(mode, wr_addr[1:0], 32'(d_out));
   assign in_run    = (state_q == ST_RUN);
   assign st_ok     = in_run & wr_en & legal;
   assign st_bad    = in_run & wr_en & ~legal;
   assign sig_hit   = (int'(wr_addr) >= int'(SIG_BASE)) && (int'(wr_addr) < SIG_END);
   assign sig_idx   = IDX_W'((wr_addr - SIG_BASE) >> 2);
   assign flag_word = (wr_addr[ADDR_WIDTH-1:2] == PASS_ADDR[ADDR_WIDTH-1:2]);

   // PASS word after merging this cycle's enabled lanes
   always_comb begin
      pflag_d = pflag_q;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) pflag_d[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   assign flag_hit = st_ok & flag_word & (pflag_d == 32'h1);
   // The flag wins over a timeout landing in the same cycle.
   assign tmo_hit  = in_run & ~flag_hit & (cycles_q == CNT_W'(TIMEOUT - 1));

   // ---- shadow and compare ----
   logic        clr;
   logic [31:0] rd_word, exp_word;
   logic        verdict_d;

   assign clr = (state_q == ST_IDLE) | ((state_q == ST_DONE) & start);

   sig_shadow_ram #(.N_SIG(N_SIG), .IDX_W(IDX_W)) u_shadow (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .we    (st_ok & sig_hit),
      .widx  (sig_idx),
      .be    (be),
      .wdata (wdata),
      .ridx  (chk_idx_q),
      .rdata (rd_word)
   );

   assign exp_word = exp_sig[32*chk_idx_q +: 32];

   always_comb begin
      fail_mask_d = fail_mask_q;
      fail_mask_d[chk_idx_q] = (rd_word != exp_word);
   end

   // Uses the mask including the last word compared this cycle.
   assign verdict_d = pass_seen_q & ~|fail_mask_d & ~misaligned_q;

   // ---- FSM ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timed_out_q  <= 1'b0;
         misaligned_q <= 1'b0;
         pass_seen_q  <= 1'b0;
         fail_mask_q  <= '0;
         cycles_q     <= '0;
         chk_idx_q    <= '0;
         pflag_q      <= '0;
      end else begin
         if (clr) begin
            timed_out_q  <= 1'b0;
            misaligned_q <= 1'b0;
            pass_seen_q  <= 1'b0;
            fail_mask_q  <= '0;
            cycles_q     <= '0;
            chk_idx_q    <= '0;
            pflag_q      <= '0;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               cycles_q <= cycles_q + 1'b1;
               if (st_bad) misaligned_q <= 1'b1;
               if (st_ok && flag_word) pflag_q <= pflag_d;
               if (flag_hit) begin
                  pass_seen_q <= 1'b1;
                  state_q     <= ST_CHECK;
               end else if (tmo_hit) begin
                  timed_out_q <= 1'b1;
                  state_q     <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               fail_mask_q <= fail_mask_d;
               if (chk_idx_q == IDX_W'(N_SIG - 1)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= verdict_d;
                  fail_q  <= ~verdict_d;
               end else begin
                  chk_idx_q <= chk_idx_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  fail_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign timed_out  = timed_out_q;
   assign misaligned = misaligned_q;
   assign fail_mask  = fail_mask_q;
   assign cycles     = cycles_q;

endmodule
